// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-control bundle between the 5-stage core datapath and hazard_flush_ctrl.
// The master side is the datapath. It drives the hazard inputs and consumes the stall/flush controls.
interface hazard_flush_ctrl_if;
   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       ex_mem_read;
   logic [4:0] ex_rd_addr;
   logic       ex_is_branch_jump;
   logic       mem_req;
   logic       dmem_ack;
   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_stall;
   logic       memwb_bubble;
   logic       mem_timeout;
   logic [1:0] state_o;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
             ex_mem_read, ex_rd_addr, ex_is_branch_jump, mem_req, dmem_ack,
      input  pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall,
             memwb_bubble, mem_timeout, state_o
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
             ex_mem_read, ex_rd_addr, ex_is_branch_jump, mem_req, dmem_ack,
      output pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall,
             memwb_bubble, mem_timeout, state_o
   );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush sequencer for the 5-stage RV64 pipeline: load-use, memory wait, and redirect shadow.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module hazard_flush_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hazard_flush_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flush_events
`endif
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t            state;
   logic [1:0]        shadow_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;

   logic lu;
   logic mem_miss;
   logic take_miss;
   logic take_redirect;
   logic take_lu;
   logic release_mem;
   logic timeout_hit;
   logic mem_hold;
   logic flush_now;
   logic lu_hold;

   // Decode: which action this cycle takes, given the state and the live pipeline inputs.
   always_comb begin
      lu = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
           ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
            (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));
      mem_miss      = hz.mem_req && !hz.dmem_ack;
      take_miss     = 1'b0;
      take_redirect = 1'b0;
      take_lu       = 1'b0;
      release_mem   = 1'b0;
      timeout_hit   = 1'b0;
      mem_hold      = 1'b0;
      flush_now     = 1'b0;
      lu_hold       = 1'b0;
      case (state)
         RUN, LU_STALL: begin
            if (mem_miss) begin
               take_miss = 1'b1;
               mem_hold  = 1'b1;
            end else if (hz.ex_is_branch_jump) begin
               take_redirect = 1'b1;
               flush_now     = 1'b1;
            end else if (lu && (state == RUN)) begin
               take_lu = 1'b1;
               lu_hold = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.dmem_ack) begin
               release_mem = 1'b1;
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
               release_mem = 1'b1;
               timeout_hit = 1'b1;
            end else begin
               mem_hold = 1'b1;
            end
         end
         REDIRECT: begin
            // A miss here freezes the wrong-path slots; the stall-then-bubble sequence disposes of them.
            if (mem_miss) begin
               take_miss = 1'b1;
               mem_hold  = 1'b1;
            end else begin
               flush_now     = 1'b1;
               take_redirect = hz.ex_is_branch_jump;
            end
         end
         default: ;
      endcase
   end

   // Outputs are forced low while reset is asserted, independent of the clock.
   always_comb begin
      hz.pc_stall     = rst_n && (mem_hold || lu_hold);
      hz.ifid_stall   = rst_n && (mem_hold || lu_hold);
      hz.ifid_flush   = rst_n && flush_now;
      hz.idex_flush   = rst_n && (flush_now || lu_hold);
      hz.exmem_stall  = rst_n && mem_hold;
      hz.memwb_bubble = rst_n && mem_hold;
      hz.mem_timeout  = timeout_q;
      hz.state_o      = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         shadow_cnt <= 2'd0;
         wait_cnt   <= '0;
         timeout_q  <= 1'b0;
      end else begin
         case (state)
            RUN, LU_STALL: begin
               if (take_miss) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end else if (take_redirect) begin
                  shadow_cnt <= 2'(FLUSH_CYCLES - 1);
                  state      <= (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
               end else if (take_lu) begin
                  state <= LU_STALL;
               end else begin
                  state <= RUN;
               end
            end
            MEM_WAIT: begin
               if (release_mem) begin
                  state    <= RUN;
                  wait_cnt <= '0;
                  if (timeout_hit) timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            REDIRECT: begin
               if (take_miss) begin
                  state      <= MEM_WAIT;
                  wait_cnt   <= '0;
                  shadow_cnt <= 2'd0;
               end else if (take_redirect) begin
                  shadow_cnt <= 2'(FLUSH_CYCLES - 1);
                  state      <= (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
               end else begin
                  shadow_cnt <= shadow_cnt - 2'd1;
                  if (shadow_cnt <= 2'd1) state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Only redirects taken from RUN/LU_STALL count as events; reloads inside the shadow do not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= 32'd0;
         perf_flush_events <= 32'd0;
      end else begin
         if (hz.pc_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (take_redirect && ((state == RUN) || (state == LU_STALL)) &&
             (perf_flush_events != 32'hFFFF_FFFF))
            perf_flush_events <= perf_flush_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
// Expected vector layout: {state[1:0], pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_bubble, mem_timeout}.
module tb_hazard_flush_ctrl;

   localparam logic [6:0] O_IDLE  = 7'b000_0000;
   localparam logic [6:0] O_LU    = 7'b110_1000;
   localparam logic [6:0] O_FLUSH = 7'b001_1000;
   localparam logic [6:0] O_MEMW  = 7'b110_0110;

   logic clk;
   logic rst_n;
   hazard_flush_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_events;
`endif

   hazard_flush_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_events (perf_flush_events)
`endif
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];
   string      tag_q[$];
   logic       exp_to = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] observed();
      return {hz.state_o, hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_flush,
              hz.exmem_stall, hz.memwb_bubble, hz.mem_timeout};
   endfunction

   // Scoreboard: compare each cycle's queued expectation mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [8:0] e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, 32'(observed()), 32'(e));
      end
   end

   task automatic set_inputs(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                             input logic u2, input logic ld, input logic [4:0] rd,
                             input logic bj, input logic req, input logic ack);
      hz.id_rs1_addr       = rs1;
      hz.id_rs2_addr       = rs2;
      hz.id_uses_rs1       = u1;
      hz.id_uses_rs2       = u2;
      hz.ex_mem_read       = ld;
      hz.ex_rd_addr        = rd;
      hz.ex_is_branch_jump = bj;
      hz.mem_req           = req;
      hz.dmem_ack          = ack;
   endtask

   // Driver: one clock cycle of inputs plus the expected state/outputs for that cycle.
   task automatic drive(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic ld, input logic [4:0] rd,
                        input logic bj, input logic req, input logic ack,
                        input logic [1:0] st, input logic [6:0] o);
      @(posedge clk);
      #1;
      set_inputs(rs1, rs2, u1, u2, ld, rd, bj, req, ack);
      exp_q.push_back({st, o[6:1], exp_to});
      tag_q.push_back(tag);
   endtask

   task automatic idle(input string tag, input logic [1:0] st, input logic [6:0] o);
      drive(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, st, o);
   endtask

   initial begin
      rst_n = 1'b0;
      set_inputs(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      #3;
      check("reset_outputs", 32'(observed()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("reset_perf_stall", perf_stall_cycles, 32'd0);
      check("reset_perf_flush", perf_flush_events, 32'd0);
`endif
      set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use on rs2
      drive("lu_hit", 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, O_LU);
      idle("lu_stall_state", 2'd1, O_IDLE);
      idle("lu_back_run", 2'd0, O_IDLE);

      // x0 destination never stalls
      drive("lu_rd0", 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, O_IDLE);
      idle("lu_rd0_after", 2'd0, O_IDLE);

      // Redirect: two flush cycles
      drive("br_flush0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, O_FLUSH);
      idle("br_flush1", 2'd3, O_FLUSH);
      idle("br_done", 2'd0, O_IDLE);

      // Redirect with simultaneous load-use: no load-use stall
      drive("br_lu_flush0", 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, O_FLUSH);
      idle("br_lu_flush1", 2'd3, O_FLUSH);
      idle("br_lu_done", 2'd0, O_IDLE);

      // Memory wait: ack low four cycles, branch ignored while waiting
      drive("mw_enter", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, O_MEMW);
      drive("mw_wait1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, O_MEMW);
      drive("mw_wait2_bj", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd2, O_MEMW);
      drive("mw_wait3", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, O_MEMW);
      drive("mw_ack", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd2, O_IDLE);
      idle("mw_done", 2'd0, O_IDLE);

      // Timeout: eight stalled wait cycles, then forced release and sticky flag
      drive("to_enter", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, O_MEMW);
      for (int i = 0; i < 8; i++)
         drive($sformatf("to_wait%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
               2'd2, O_MEMW);
      drive("to_release", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, O_IDLE);
      exp_to = 1'b1;
      idle("to_sticky0", 2'd0, O_IDLE);
      idle("to_sticky1", 2'd0, O_IDLE);

      // Memory miss during redirect shadow drops remaining flushes
      drive("rd_mw_br", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, O_FLUSH);
      drive("rd_mw_miss", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd3, O_MEMW);
      drive("rd_mw_ack", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd2, O_IDLE);
      idle("rd_mw_done", 2'd0, O_IDLE);

      // Redirect arriving in LU_STALL
      drive("lus_br_lu", 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, O_LU);
      drive("lus_br_flush0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, O_FLUSH);
      idle("lus_br_flush1", 2'd3, O_FLUSH);
      idle("lus_br_done", 2'd0, O_IDLE);

      // Random load-use patterns over a small register window
      for (int i = 0; i < 16; i++) begin
         logic [4:0] rs1, rs2, rd;
         logic u1, u2, ld, hit;
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 3));
         u1  = 1'($urandom_range(0, 1));
         u2  = 1'($urandom_range(0, 1));
         ld  = 1'($urandom_range(0, 1));
         hit = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         drive($sformatf("rnd_lu%0d", i), rs1, rs2, u1, u2, ld, rd, 1'b0, 1'b0, 1'b0,
               2'd0, hit ? O_LU : O_IDLE);
         idle($sformatf("rnd_after%0d", i), hit ? 2'd1 : 2'd0, O_IDLE);
      end

      // Asynchronous reset in REDIRECT with one flush cycle remaining
      drive("ar_br", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, O_FLUSH);
      idle("ar_redirect", 2'd3, O_FLUSH);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      set_inputs(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
      #1;
      check("ar_async_outputs", 32'(observed()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("ar_perf_stall", perf_stall_cycles, 32'd0);
      check("ar_perf_flush", perf_flush_events, 32'd0);
`endif
      @(posedge clk);
      #1;
      check("ar_held_outputs", 32'(observed()), 32'd0);
      set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_to = 1'b0;
      idle("ar_after0", 2'd0, O_IDLE);
      idle("ar_after1", 2'd0, O_IDLE);
      drive("ar_lu", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 2'd0, O_LU);
      idle("ar_lu_stall", 2'd1, O_IDLE);

      @(negedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
